// File: rtl/rl_env_pkg.sv
// rtl/rl_env_pkg.sv - shared constants for the RL environment reward path
package rl_env_pkg;

  localparam int RWD_WL             = 32;
  localparam int PENDULUM_MAX_STEPS = 200;

  localparam logic [31:0] FP32_ZERO      = 32'h0000_0000;
  localparam logic [31:0] FP32_SIGN_MASK = 32'h8000_0000;

  function automatic logic [31:0] fp32_neg(input logic [31:0] x);
    return x ^ FP32_SIGN_MASK;
  endfunction

endpackage

// File: rtl/rwd_collector_if.sv
// rtl/rwd_collector_if.sv - reward input stream and tagged reward output handshake
interface rwd_collector_if #(
  parameter int RWD_WL  = rl_env_pkg::RWD_WL,
  parameter int STEP_WL = 8
);

  logic              i_rwd_valid;
  logic [RWD_WL-1:0] i_rwd;
  logic              i_rwd_ready;
  logic              o_rwd_valid;
  logic [RWD_WL-1:0] o_rwd;
  logic [STEP_WL-1:0] o_step;
  logic              o_done;

  modport slave (
    input  i_rwd_valid, i_rwd, i_rwd_ready,
    output o_rwd_valid, o_rwd, o_step, o_done
  );

  modport master (
    output i_rwd_valid, i_rwd, i_rwd_ready,
    input  o_rwd_valid, o_rwd, o_step, o_done
  );

endinterface

// File: rtl/rwd_collector_fifo.sv
// rtl/rwd_collector_fifo.sv - first-word-fall-through FIFO with flush, fill and wrap-bit pointers
module sync_fwft_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_fill
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop;
  logic             w_wr_en;
  logic [AW-1:0]    w_wr_addr;

  assign o_fill    = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (o_fill == (AW+1)'(DEPTH));
  assign w_pop     = i_pop && !o_empty && !i_flush;
  assign w_wr_en   = i_push && (i_flush || !o_full || w_pop);
  // A flush rewinds both pointers, so a same-cycle push lands in slot 0.
  assign w_wr_addr = i_flush ? '0 : r_wr_ptr[AW-1:0];
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= {{AW{1'b0}}, w_wr_en};
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= i_data;
  end

endmodule

// File: rtl/rwd_collector.sv
// rtl/rwd_collector.sv - buffers rewards, tags step index and truncation, flags overflow
module rwd_collector
  import rl_env_pkg::*;
#(
  parameter int RWD_WL    = rl_env_pkg::RWD_WL,
  parameter int DEPTH     = 4,
  parameter int MAX_STEPS = PENDULUM_MAX_STEPS,
  parameter int STEP_WL   = 8,
  parameter int EP_WL     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_ep_start,
  rwd_collector_if.slave         bus,
  output logic [EP_WL-1:0]       o_ep_cnt,
  output logic                   o_ovf,
  output logic [$clog2(DEPTH):0] o_fill
);

  localparam int                 EW        = RWD_WL + STEP_WL + 1;
  localparam logic [STEP_WL-1:0] LAST_STEP = STEP_WL'(MAX_STEPS - 1);

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  logic [STEP_WL-1:0] r_step_cnt;
  logic [EP_WL-1:0]   r_ep_cnt;
  logic               r_ovf;
  logic [STEP_WL-1:0] w_tag_step;
  logic               w_tag_done;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push;
  logic [EW-1:0]      w_wr_entry;
  logic [EW-1:0]      w_rd_entry;

  // Assertion is immediate, release waits two edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_pop      = bus.o_rwd_valid && bus.i_rwd_ready && !i_ep_start;
  assign w_push     = bus.i_rwd_valid && (i_ep_start || !w_full || w_pop);
  assign w_tag_step = i_ep_start ? '0 : r_step_cnt;
  assign w_tag_done = (w_tag_step == LAST_STEP);
  assign w_wr_entry = {bus.i_rwd, w_tag_step, w_tag_done};

  // A dropped sample leaves the counter alone, so a lost done sample is retried.
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_step_cnt <= '0;
      r_ep_cnt   <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (i_ep_start) begin
        r_step_cnt <= '0;
        r_ovf      <= 1'b0;
      end
      if (w_push) begin
        if (w_tag_done) begin
          r_step_cnt <= '0;
          r_ep_cnt   <= r_ep_cnt + 1'b1;
        end else begin
          r_step_cnt <= w_tag_step + 1'b1;
        end
      end else if (bus.i_rwd_valid) begin
        r_ovf <= 1'b1;
      end
    end
  end

  sync_fwft_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (w_rst_n),
    .i_flush (i_ep_start),
    .i_push  (w_push),
    .i_data  (w_wr_entry),
    .i_pop   (w_pop),
    .o_data  (w_rd_entry),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_fill  (o_fill)
  );

  assign bus.o_rwd_valid = !w_empty;
  assign {bus.o_rwd, bus.o_step, bus.o_done} = w_rd_entry;
  assign o_ep_cnt = r_ep_cnt;
  assign o_ovf    = r_ovf;

endmodule

// File: doc/rwd_collector.md
Name: rwd_collector

Overview:
- Consumer end of the reward stream produced by the Pendulum reward compute block. That producer has no backpressure: a valid-only float32 `o_rwd_valid`/`o_rwd` stream.
- Buffers rewards in a small FIFO and tags each one with its episode step index and a truncation flag (done at `MAX_STEPS`).
- Presents each entry to the agent-side consumer over a valid/ready handshake.
- Detects and flags overflow, because the producer cannot be stalled.

Parameters:
- `RWD_WL`, 32, reward word width (IEEE-754 single; passed through unmodified).
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `MAX_STEPS`, 200, steps per episode before truncation (Pendulum-v1 limit).
- `STEP_WL`, 8, step counter width; must satisfy 2^`STEP_WL` ≥ `MAX_STEPS`.
- `EP_WL`, 16, episode counter width.

Ports:
- `i_clk`, in, 1, clock.
- `i_rst_n`, in, 1, asynchronous active-low reset.
- `i_ep_start`, in, 1, one-cycle pulse that starts a new episode (flush and clear).
- `i_rwd_valid`, in, 1, reward valid from the reward compute block.
- `i_rwd`, in, `RWD_WL`, reward data.
- `o_rwd_valid`, out, 1, head entry available.
- `i_rwd_ready`, in, 1, downstream accepts the head entry.
- `o_rwd`, out, `RWD_WL`, head reward.
- `o_step`, out, `STEP_WL`, step index of the head entry.
- `o_done`, out, 1, head entry is the last step of its episode.
- `o_ep_cnt`, out, `EP_WL`, number of episodes completed (counted at push).
- `o_ovf`, out, 1, sticky: a reward was dropped.
- `o_fill`, out, clog2(`DEPTH`)+1, FIFO occupancy.

Behaviour:
- **Reset** (`i_rst_n`=0, async):
  - FIFO is emptied and pointers are 0.
  - Step counter is 0; `o_ep_cnt`=0; `o_ovf`=0; `o_fill`=0; `o_rwd_valid`=0.
  - `o_rwd`, `o_step` and `o_done` read 0.
  - Deassertion is synchronised internally via 2 flops.
- **Push** when `i_rwd_valid`=1 and (not full, or pop in the same cycle):
  - Write the entry {`i_rwd`, step_cnt, done}, where done = (step_cnt == `MAX_STEPS`-1).
  - If done: step_cnt goes to 0 and `o_ep_cnt` increments, wrapping at 2^`EP_WL`. Otherwise step_cnt increments.
- **Drop** when `i_rwd_valid`=1, FIFO is full and there is no pop:
  - The sample is discarded and `o_ovf` is set.
  - step_cnt does not advance.
  - `o_ovf` clears only on reset or `i_ep_start`.
- **Pop** when `o_rwd_valid` && `i_rwd_ready`: the head advances. Ready while empty is ignored.
- **Output ordering:**
  - The FIFO is first-word-fall-through from registered storage.
  - A push in cycle N gives `o_rwd_valid`=1 in cycle N+1. Latency is 1 cycle when empty.
  - Head outputs hold stable while `o_rwd_valid`=1 and `i_rwd_ready`=0.
- **Simultaneous push and pop:**
  - Full: both happen and occupancy is unchanged.
  - Empty: the pop is ignored; the push lands.
- **`i_ep_start`** (highest priority, synchronous):
  - Flushes the FIFO, sets step_cnt to 0 and clears `o_ovf`.
  - `o_ep_cnt` is unchanged.
  - A pop in the same cycle is discarded.
  - If `i_rwd_valid`=1 in the same cycle, that sample is written as step 0 of the new episode into the now-empty FIFO (`o_fill`=1 next cycle).
- **Episode boundary with the FIFO full:** if a done sample is dropped, the episode has not ended. step_cnt stays at `MAX_STEPS`-1 so the next accepted sample carries done.
- **Data path:** reward bits pass through bit-exact; no float arithmetic.
- **Structure:** no state machine beyond the counters; pointers are `DEPTH`-wrapping with an extra wrap bit for full/empty.

Decomposition:
- Shared package (`rl_env_pkg`):
  - `RWD_WL`, `PENDULUM_MAX_STEPS`=200.
  - Float constants `FP32_ZERO`, `FP32_SIGN_MASK` (used elsewhere for negation).
- One sub-module, `sync_fwft_fifo`, parameterised on width and depth.
  - Entry width is `RWD_WL`+`STEP_WL`+1.
  - Provides full, empty and fill, plus a flush input.
- Step/episode counters and overflow logic live in `rwd_collector`.

Test Plan:
1. **Single push:** reset, then one push of `i_rwd`=32'hC0490FDB (−π) with ready=1.
   - Next cycle: `o_rwd_valid`=1, `o_rwd`=32'hC0490FDB, `o_step`=0, `o_done`=0.
   - Cycle after: `o_rwd_valid`=0.
2. **Full episode:** 200 pushes with ready held 1.
   - Entry 199 has `o_step`=199 and `o_done`=1; `o_ep_cnt`=1 after it.
   - Push 201 has `o_step`=0.
3. **Overflow:** ready=0; push 5 values 1..5.
   - `o_fill`=4, `o_ovf`=1, value 5 dropped, next step tag is 4.
   - Then ready=1: outputs are 1,2,3,4 with steps 0..3.
4. **Full push/pop:** FIFO full; push 32'h3F800000 and pop in the same cycle.
   - No overflow, `o_fill` stays 4, new value is last out.
5. **Episode start with push:** mid-episode (step 57, `o_fill`=3, `o_ovf`=1), pulse `i_ep_start` together with push 32'h40000000.
   - Next cycle: `o_fill`=1, `o_rwd`=32'h40000000, `o_step`=0, `o_ovf`=0, `o_ep_cnt` unchanged.
6. **Reset mid-traffic:** assert `i_rst_n` low asynchronously between clock edges during traffic.
   - All outputs go to 0 immediately.
   - After release plus 2 cycles, the first push is tagged step 0.
